// File: rtl/pingpong_raddr_gen_if.sv
// Handshake and address bundle between the ping-pong controller and its neighbours.
// The master modport is the controller side; the slave modport is the upstream/downstream side.
interface pingpong_raddr_gen_if #(
    parameter int unsigned ADDR_W = 4
);
    logic              WR_VALID;
    logic              WR_READY;
    logic              WEN;
    logic [ADDR_W-1:0] WADDR;
    logic              WBANK;
    logic              RD_ALLOW;
    logic              REN;
    logic [ADDR_W-1:0] RADDR;
    logic              RBANK;
    logic              GEN_RADDR_START;
    logic              READ_ONE_MATRIX;
    logic              ONE_BANK_FULL;
    logic              TWO_BANK_FULL;

    modport master (
        input  WR_VALID, RD_ALLOW, READ_ONE_MATRIX,
        output WR_READY, WEN, WADDR, WBANK, REN, RADDR, RBANK,
               GEN_RADDR_START, ONE_BANK_FULL, TWO_BANK_FULL
    );

    modport slave (
        output WR_VALID, RD_ALLOW, READ_ONE_MATRIX,
        input  WR_READY, WEN, WADDR, WBANK, REN, RADDR, RBANK,
               GEN_RADDR_START, ONE_BANK_FULL, TWO_BANK_FULL
    );
endinterface

// File: rtl/pingpong_raddr_gen.sv
// Two-bank ping-pong buffer controller: write pointer alternates banks, each full bank
// is read back as 8 full-depth passes and freed when the downstream mux reports completion.
module pingpong_raddr_gen #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                        SYS_CLK,
    input  logic                        SYS_RST,
    pingpong_raddr_gen_if.master        bus
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        full_q, full_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic              wbank_q, wbank_d;
    logic              rbank_q, rbank_d;

    logic wr_ready_c;
    logic wen_c;
    logic ren_c;
    logic pass_end_c;

    // Handshake strobes derived from current state and inputs
    always_comb begin
        wr_ready_c = ~(full_q[0] & full_q[1]);
        wen_c      = bus.WR_VALID & wr_ready_c;
        ren_c      = (state_q == READ) & bus.RD_ALLOW;
        pass_end_c = ren_c & (raddr_q == LAST_ADDR);
    end

    // Next-state: write pointer, read pointer, bank occupancy and read FSM
    always_comb begin
        state_d = state_q;
        full_d  = full_q;
        waddr_d = waddr_q;
        raddr_d = raddr_q;
        wbank_d = wbank_q;
        rbank_d = rbank_q;

        if (wen_c) begin
            if (waddr_q == LAST_ADDR) begin
                waddr_d         = '0;
                full_d[wbank_q] = 1'b1;
                wbank_d         = ~wbank_q;
            end else begin
                waddr_d = waddr_q + 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (full_q[rbank_q]) begin
                    state_d = READ;
                end
            end
            READ: begin
                if (ren_c) begin
                    raddr_d = (raddr_q == LAST_ADDR) ? '0 : raddr_q + 1'b1;
                end
                // Release may coincide with a write completing the other bank
                if (bus.READ_ONE_MATRIX) begin
                    full_d[rbank_q] = 1'b0;
                    rbank_d         = ~rbank_q;
                    raddr_d         = '0;
                    state_d         = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST) begin
            state_q <= IDLE;
            full_q  <= '0;
            waddr_q <= '0;
            raddr_q <= '0;
            wbank_q <= 1'b0;
            rbank_q <= 1'b0;
        end else begin
            state_q <= state_d;
            full_q  <= full_d;
            waddr_q <= waddr_d;
            raddr_q <= raddr_d;
            wbank_q <= wbank_d;
            rbank_q <= rbank_d;
        end
    end

    assign bus.WR_READY        = wr_ready_c;
    assign bus.WEN             = wen_c;
    assign bus.WADDR           = waddr_q;
    assign bus.WBANK           = wbank_q;
    assign bus.REN             = ren_c;
    assign bus.RADDR           = raddr_q;
    assign bus.RBANK           = rbank_q;
    assign bus.GEN_RADDR_START = pass_end_c;
    assign bus.ONE_BANK_FULL   = full_q[0] ^ full_q[1];
    assign bus.TWO_BANK_FULL   = full_q[0] & full_q[1];
endmodule

// File: doc/pingpong_raddr_gen.md
# pingpong_raddr_gen

Ping-pong two-bank buffer controller feeding `gen_mux_1_8_ctrl`. It generates write addresses for an incoming word stream alternating between bank 0 and bank 1, and reports bank occupancy. Each full bank is read back as 8 full-depth passes, one pass per bit position selected by the downstream 1-of-8 mux. The block strobes `GEN_RADDR_START` at the end of every pass and frees the bank when the downstream stage returns `READ_ONE_MATRIX`.

## Interface
- `ADDR_W`, 4: bank address width.
- `DEPTH`, 16: words per bank. Must equal 2^`ADDR_W`.
- Pass count is fixed at 8, matching the 3-bit downstream select.

Ports:
- `SYS_CLK` in 1: single clock, rising edge.
- `SYS_RST` in 1: synchronous, active-high reset.
- `WR_VALID` in 1: upstream word available.
- `WR_READY` out 1: a bank slot is free; equals `!TWO_BANK_FULL`.
- `WEN` out 1: write strobe; equals `WR_VALID & WR_READY`.
- `WADDR` out `ADDR_W`: write address, registered.
- `WBANK` out 1: bank being written, registered.
- `RD_ALLOW` in 1: downstream accepts a read this cycle (stall control).
- `REN` out 1: read strobe.
- `RADDR` out `ADDR_W`: read address, registered.
- `RBANK` out 1: bank being read, registered.
- `GEN_RADDR_START` out 1: end-of-pass strobe to `gen_mux_1_8_ctrl`.
- `READ_ONE_MATRIX` in 1: 8th pass done, returned by `gen_mux_1_8_ctrl`.
- `ONE_BANK_FULL` out 1: exactly one bank full.
- `TWO_BANK_FULL` out 1: both banks full.

## Operation
- State: `full[1:0]`, write pointer (`WBANK`, `WADDR`), read pointer (`RBANK`, `RADDR`), read FSM {`IDLE`, `READ`}.
- Write side, on each `WEN`:
  - `WADDR` increments.
  - At `WADDR == DEPTH-1`: `WADDR` wraps to 0, `full[WBANK]` is set, `WBANK` toggles.
  - Writes never target a full bank. With `TWO_BANK_FULL`, `WEN` stays low.
- Read FSM:
  - `IDLE`: `REN = 0`. Go to `READ` when `full[RBANK]` is set.
  - `READ`: `REN = RD_ALLOW`. On each `REN`, `RADDR` increments.
  - At `RADDR == DEPTH-1` with `REN`: `GEN_RADDR_START = 1` for that cycle, and `RADDR` wraps to 0 for the next pass.
  - `GEN_RADDR_START = (state == READ) & REN & (RADDR == DEPTH-1)`. It is combinational and never asserts twice for the same pass.
- Release: on `READ_ONE_MATRIX` while in `READ`, clear `full[RBANK]`, toggle `RBANK`, clear `RADDR`, go to `IDLE`.
  - `READ_ONE_MATRIX` is combinational from `GEN_RADDR_START` downstream, so release lands on the same edge as the 8th pass end.
  - `READ_ONE_MATRIX` in `IDLE` is a protocol error and is ignored.
- Flags: `ONE_BANK_FULL = full[0] ^ full[1]`, `TWO_BANK_FULL = full[0] & full[1]`.
- Simultaneous events:
  - Write-completion of bank X and release of bank Y on the same edge both take effect.
  - X == Y is impossible, because only non-full banks are written.
  - The write pointer does not stall on release. `WR_READY` rises the cycle after release.
- Reset: all registers are cleared on the next edge, including mid-read or mid-write. No residual `GEN_RADDR_START`.

## Timing
- Reset values:
  - `WADDR = 0`, `WBANK = 0`, `RADDR = 0`, `RBANK = 0`, `full = 00`, state `IDLE`.
  - Outputs: `REN = 0`, `GEN_RADDR_START = 0`, `ONE_BANK_FULL = 0`, `TWO_BANK_FULL = 0`, `WR_READY = 1`.
- Write throughput: 1 word per cycle.
- Full-to-read latency:
  - Last write `WEN` in cycle t.
  - `full` is visible in t+1 (FSM sees it in `IDLE`).
  - `READ` and first possible `REN` in t+2.
- Read throughput: 1 address per cycle when `RD_ALLOW = 1`. One bank takes 8·`DEPTH` `REN` cycles. `RD_ALLOW = 0` freezes `RADDR` with no skipped or repeated addresses.
- Bank free:
  - Release edge ends cycle r.
  - `full` is cleared from r+1.
  - `WR_READY` is high in r+1 if it was low.
  - If the other bank is full, the next read starts in r+2.

## Test plan
- Single bank, `DEPTH = 16`, `RD_ALLOW = 1`:
  - 16 writes give `WADDR` 0..15 on bank 0, then `ONE_BANK_FULL = 1`.
  - `REN` runs 128 cycles with `RADDR` 0..15 repeated 8 times.
  - 8 `GEN_RADDR_START` pulses, at `RADDR = 15`.
  - After the 8th, `full = 00` and `RBANK = 1`.
- Both full:
  - 32 back-to-back writes with `RD_ALLOW = 0` give `TWO_BANK_FULL = 1` and `WR_READY = 0`.
  - A 33rd `WR_VALID` produces no `WEN`.
  - After release of bank 0, `WR_READY = 1` in the next cycle and writes resume at bank 0, `WADDR = 0`.
- Stall: toggle `RD_ALLOW` randomly during `READ`. The `RADDR` sequence is gap-free, and exactly 8 pulses occur per bank.
- Simultaneous events: time the 16th write to bank 1 on the same edge as release of bank 0. After that edge, `full = 10`, `RBANK = 1`, `WBANK = 0`, and the next read starts on bank 1.
- Mid-read reset: assert `SYS_RST` at pass 3, `RADDR = 7`. Next cycle all values match the reset values above, and no `GEN_RADDR_START` fires.
- Spurious `READ_ONE_MATRIX` in `IDLE`: no change to `full`, `RBANK` or state.
